// File: rtl/lsu_wb.sv
// Load/store and writeback stage: drives the register-file write port directly for ALU ops,
// runs a req/gnt/rvalid bus transaction for loads and stores, with a watchdog abort.
module lsu_wb #(
  parameter int TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        I_valid,
  output logic        O_ready,
  input  logic [3:0]  I_op,
  input  logic [31:0] I_addr,
  input  logic [31:0] I_wdata,
  input  logic [31:0] I_alu_result,
  input  logic        I_rd_we,
  input  logic [4:0]  I_rd_waddr,
  output logic        O_mem_req,
  input  logic        I_mem_gnt,
  output logic        O_mem_we,
  output logic [31:0] O_mem_addr,
  output logic [3:0]  O_mem_wstrb,
  output logic [31:0] O_mem_wdata,
  input  logic        I_mem_rvalid,
  input  logic [31:0] I_mem_rdata,
  output logic        O_rd_we,
  output logic [4:0]  O_rd_waddr,
  output logic [31:0] O_rd_wdata,
  output logic        O_misalign,
  output logic        O_bus_err
);

  localparam logic [3:0] OP_LB  = 4'b0001;
  localparam logic [3:0] OP_LH  = 4'b0010;
  localparam logic [3:0] OP_LW  = 4'b0011;
  localparam logic [3:0] OP_LBU = 4'b0100;
  localparam logic [3:0] OP_LHU = 4'b0101;
  localparam logic [3:0] OP_SB  = 4'b1001;
  localparam logic [3:0] OP_SH  = 4'b1010;
  localparam logic [3:0] OP_SW  = 4'b1011;

  localparam logic [7:0] WD_LAST = 8'(TIMEOUT - 1);

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT} state_t;

  state_t      state;
  logic [7:0]  wd_cnt;
  logic [3:0]  op_q;
  logic [1:0]  off_q;
  logic        rd_we_q;
  logic [4:0]  rd_addr_q;

  logic        is_load;
  logic        is_store;
  logic        misaligned;
  logic [3:0]  wstrb_n;
  logic [31:0] wdata_n;
  logic [31:0] lane_shift;
  logic [7:0]  ld_byte;
  logic [15:0] ld_half;
  logic [31:0] ld_data;
  logic        wd_expired;

  assign O_ready    = (state == S_IDLE);
  assign O_mem_req  = (state == S_REQ);
  assign wd_expired = (wd_cnt == WD_LAST);

  // Decode the incoming op: memory class, alignment, and store lane encoding.
  always_comb begin
    is_load    = 1'b0;
    is_store   = 1'b0;
    misaligned = 1'b0;
    wstrb_n    = 4'b0000;
    wdata_n    = 32'h0;
    case (I_op)
      OP_LB, OP_LBU: is_load = 1'b1;
      OP_LH, OP_LHU: begin
        is_load    = 1'b1;
        misaligned = I_addr[0];
      end
      OP_LW: begin
        is_load    = 1'b1;
        misaligned = (I_addr[1:0] != 2'b00);
      end
      OP_SB: begin
        is_store = 1'b1;
        wstrb_n  = 4'b0001 << I_addr[1:0];
        wdata_n  = {4{I_wdata[7:0]}};
      end
      OP_SH: begin
        is_store   = 1'b1;
        misaligned = I_addr[0];
        wstrb_n    = I_addr[1] ? 4'b1100 : 4'b0011;
        wdata_n    = {2{I_wdata[15:0]}};
      end
      OP_SW: begin
        is_store   = 1'b1;
        misaligned = (I_addr[1:0] != 2'b00);
        wstrb_n    = 4'b1111;
        wdata_n    = I_wdata;
      end
      default: ;
    endcase
  end

  // Pick the addressed lane out of the returned word and extend it.
  always_comb begin
    lane_shift = I_mem_rdata >> {off_q, 3'b000};
    ld_byte    = lane_shift[7:0];
    ld_half    = off_q[1] ? I_mem_rdata[31:16] : I_mem_rdata[15:0];
    case (op_q)
      OP_LB:   ld_data = {{24{ld_byte[7]}}, ld_byte};
      OP_LBU:  ld_data = {24'h0, ld_byte};
      OP_LH:   ld_data = {{16{ld_half[15]}}, ld_half};
      OP_LHU:  ld_data = {16'h0, ld_half};
      default: ld_data = I_mem_rdata;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= S_IDLE;
      wd_cnt      <= 8'h0;
      op_q        <= 4'h0;
      off_q       <= 2'b00;
      rd_we_q     <= 1'b0;
      rd_addr_q   <= 5'h0;
      O_mem_we    <= 1'b0;
      O_mem_addr  <= 32'h0;
      O_mem_wstrb <= 4'h0;
      O_mem_wdata <= 32'h0;
      O_rd_we     <= 1'b0;
      O_rd_waddr  <= 5'h0;
      O_rd_wdata  <= 32'h0;
      O_misalign  <= 1'b0;
      O_bus_err   <= 1'b0;
    end else begin
      O_rd_we    <= 1'b0;
      O_misalign <= 1'b0;
      O_bus_err  <= 1'b0;
      case (state)
        S_IDLE: begin
          if (I_valid) begin
            if (is_load || is_store) begin
              if (misaligned) begin
                O_misalign <= 1'b1;
              end else begin
                op_q        <= I_op;
                off_q       <= I_addr[1:0];
                rd_we_q     <= I_rd_we;
                rd_addr_q   <= I_rd_waddr;
                O_mem_we    <= is_store;
                O_mem_addr  <= {I_addr[31:2], 2'b00};
                O_mem_wstrb <= wstrb_n;
                O_mem_wdata <= wdata_n;
                wd_cnt      <= 8'h0;
                state       <= S_REQ;
              end
            end else begin
              O_rd_we    <= I_rd_we && (I_rd_waddr != 5'd0);
              O_rd_waddr <= I_rd_waddr;
              O_rd_wdata <= I_alu_result;
            end
          end
        end
        // Watchdog expiry is checked before the grant so the count never runs past its limit.
        S_REQ: begin
          if (wd_expired) begin
            O_bus_err <= 1'b1;
            state     <= S_IDLE;
          end else begin
            wd_cnt <= wd_cnt + 8'd1;
            if (I_mem_gnt) state <= S_WAIT;
          end
        end
        S_WAIT: begin
          if (I_mem_rvalid) begin
            state <= S_IDLE;
            if (!O_mem_we && rd_we_q && (rd_addr_q != 5'd0)) begin
              O_rd_we    <= 1'b1;
              O_rd_waddr <= rd_addr_q;
              O_rd_wdata <= ld_data;
            end
          end else if (wd_expired) begin
            O_bus_err <= 1'b1;
            state     <= S_IDLE;
          end else begin
            wd_cnt <= wd_cnt + 8'd1;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_lsu_wb.sv
// Directed bench for lsu_wb with a short watchdog; expected values are hand-computed.
module tb_lsu_wb;

  logic        clk;
  logic        rst;
  logic        I_valid;
  logic        O_ready;
  logic [3:0]  I_op;
  logic [31:0] I_addr;
  logic [31:0] I_wdata;
  logic [31:0] I_alu_result;
  logic        I_rd_we;
  logic [4:0]  I_rd_waddr;
  logic        O_mem_req;
  logic        I_mem_gnt;
  logic        O_mem_we;
  logic [31:0] O_mem_addr;
  logic [3:0]  O_mem_wstrb;
  logic [31:0] O_mem_wdata;
  logic        I_mem_rvalid;
  logic [31:0] I_mem_rdata;
  logic        O_rd_we;
  logic [4:0]  O_rd_waddr;
  logic [31:0] O_rd_wdata;
  logic        O_misalign;
  logic        O_bus_err;

  int totalCount = 0;
  int badCount   = 0;
  int reqCycles;

  lsu_wb #(.TIMEOUT(8)) dut (
    .clk(clk), .rst(rst),
    .I_valid(I_valid), .O_ready(O_ready), .I_op(I_op), .I_addr(I_addr),
    .I_wdata(I_wdata), .I_alu_result(I_alu_result), .I_rd_we(I_rd_we),
    .I_rd_waddr(I_rd_waddr), .O_mem_req(O_mem_req), .I_mem_gnt(I_mem_gnt),
    .O_mem_we(O_mem_we), .O_mem_addr(O_mem_addr), .O_mem_wstrb(O_mem_wstrb),
    .O_mem_wdata(O_mem_wdata), .I_mem_rvalid(I_mem_rvalid), .I_mem_rdata(I_mem_rdata),
    .O_rd_we(O_rd_we), .O_rd_waddr(O_rd_waddr), .O_rd_wdata(O_rd_wdata),
    .O_misalign(O_misalign), .O_bus_err(O_bus_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    totalCount++;
    if (observed !== expected) begin
      badCount++;
      $display("[TB] FAIL %s: got 0x%08h, want 0x%08h", tag, observed, expected);
    end
  endtask

  // Advance one clock; inputs change and outputs are sampled 1ns after the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic [3:0] op, input logic [31:0] addr, input logic [31:0] wdata,
                               input logic [31:0] alu, input logic rdWe, input logic [4:0] rdAddr);
    I_valid      = 1'b1;
    I_op         = op;
    I_addr       = addr;
    I_wdata      = wdata;
    I_alu_result = alu;
    I_rd_we      = rdWe;
    I_rd_waddr   = rdAddr;
  endtask

  task automatic doLoad(input string tag, input logic [3:0] op, input logic [31:0] addr, input logic [4:0] rd,
                        input logic [31:0] rdata, input logic expWe, input logic [31:0] expData);
    applyStimulus(op, addr, 32'h0, 32'h0, 1'b1, rd);
    tick();
    I_valid   = 1'b0;
    I_mem_gnt = 1'b1;
    tick();
    I_mem_gnt    = 1'b0;
    I_mem_rvalid = 1'b1;
    I_mem_rdata  = rdata;
    tick();
    I_mem_rvalid = 1'b0;
    checkOutput({tag, "_we"}, 32'(O_rd_we), 32'(expWe));
    if (expWe) checkOutput({tag, "_data"}, O_rd_wdata, expData);
    checkOutput({tag, "_ready"}, 32'(O_ready), 32'd1);
  endtask

  initial begin
    rst = 1'b1;
    I_valid = 1'b0; I_op = 4'h0; I_addr = 32'h0; I_wdata = 32'h0; I_alu_result = 32'h0;
    I_rd_we = 1'b0; I_rd_waddr = 5'h0; I_mem_gnt = 1'b0; I_mem_rvalid = 1'b0; I_mem_rdata = 32'h0;
    #1;
    checkOutput("rst_ready", 32'(O_ready), 32'd1);
    checkOutput("rst_req", 32'(O_mem_req), 32'd0);
    checkOutput("rst_rdwe", 32'(O_rd_we), 32'd0);
    checkOutput("rst_addr", O_mem_addr, 32'h0);
    checkOutput("rst_wstrb", 32'(O_mem_wstrb), 32'h0);
    tick(); tick();
    rst = 1'b0;
    tick();

    // LW with gnt in the first REQ cycle and rvalid two cycles later
    applyStimulus(4'b0011, 32'h8000_0104, 32'h0, 32'h0, 1'b1, 5'd10);
    tick();
    I_valid = 1'b0;
    checkOutput("lw_req", 32'(O_mem_req), 32'd1);
    checkOutput("lw_ready", 32'(O_ready), 32'd0);
    checkOutput("lw_addr", O_mem_addr, 32'h8000_0104);
    checkOutput("lw_wstrb", 32'(O_mem_wstrb), 32'h0);
    checkOutput("lw_we", 32'(O_mem_we), 32'd0);
    I_mem_gnt = 1'b1;
    tick();
    I_mem_gnt = 1'b0;
    checkOutput("lw_req_drop", 32'(O_mem_req), 32'd0);
    tick();
    I_mem_rvalid = 1'b1;
    I_mem_rdata  = 32'hDEAD_BEEF;
    checkOutput("lw_no_early_wr", 32'(O_rd_we), 32'd0);
    tick();
    I_mem_rvalid = 1'b0;
    checkOutput("lw_rdwe", 32'(O_rd_we), 32'd1);
    checkOutput("lw_waddr", 32'(O_rd_waddr), 32'd10);
    checkOutput("lw_wdata", O_rd_wdata, 32'hDEAD_BEEF);
    tick();
    checkOutput("lw_rdwe_pulse", 32'(O_rd_we), 32'd0);

    // Lane extraction and extension from 0x80FF1234
    doLoad("lb3", 4'b0001, 32'h8000_0003, 5'd1, 32'h80FF_1234, 1'b1, 32'hFFFF_FF80);
    doLoad("lbu3", 4'b0100, 32'h8000_0003, 5'd2, 32'h80FF_1234, 1'b1, 32'h0000_0080);
    doLoad("lh2", 4'b0010, 32'h8000_0002, 5'd3, 32'h80FF_1234, 1'b1, 32'hFFFF_80FF);
    doLoad("lhu0", 4'b0101, 32'h8000_0000, 5'd4, 32'h80FF_1234, 1'b1, 32'h0000_1234);
    doLoad("lb1", 4'b0001, 32'h8000_0001, 5'd6, 32'h80FF_1234, 1'b1, 32'h0000_0012);
    doLoad("lw_x0", 4'b0011, 32'h8000_0010, 5'd0, 32'h1111_2222, 1'b0, 32'h0);

    // SH to upper half; rd_we asserted on input must still give no write
    applyStimulus(4'b1010, 32'h8000_0006, 32'h0000_ABCD, 32'h0, 1'b1, 5'd7);
    tick();
    I_valid = 1'b0;
    checkOutput("sh_we", 32'(O_mem_we), 32'd1);
    checkOutput("sh_addr", O_mem_addr, 32'h8000_0004);
    checkOutput("sh_wstrb", 32'(O_mem_wstrb), 32'b1100);
    checkOutput("sh_wdata", O_mem_wdata, 32'hABCD_ABCD);
    I_mem_gnt = 1'b1;
    tick();
    I_mem_gnt    = 1'b0;
    I_mem_rvalid = 1'b1;
    tick();
    I_mem_rvalid = 1'b0;
    checkOutput("sh_no_wr", 32'(O_rd_we), 32'd0);
    checkOutput("sh_ready", 32'(O_ready), 32'd1);

    // SB lane 1
    applyStimulus(4'b1001, 32'h8000_0009, 32'h0000_0012, 32'h0, 1'b0, 5'd0);
    tick();
    I_valid = 1'b0;
    checkOutput("sb_wstrb", 32'(O_mem_wstrb), 32'b0010);
    checkOutput("sb_wdata", O_mem_wdata, 32'h1212_1212);
    I_mem_gnt = 1'b1;
    tick();
    I_mem_gnt    = 1'b0;
    I_mem_rvalid = 1'b1;
    tick();
    I_mem_rvalid = 1'b0;

    // Misaligned LW
    applyStimulus(4'b0011, 32'h8000_0002, 32'h0, 32'h0, 1'b1, 5'd8);
    tick();
    I_valid = 1'b0;
    checkOutput("mis_pulse", 32'(O_misalign), 32'd1);
    checkOutput("mis_req", 32'(O_mem_req), 32'd0);
    checkOutput("mis_ready", 32'(O_ready), 32'd1);
    tick();
    checkOutput("mis_pulse_end", 32'(O_misalign), 32'd0);
    checkOutput("mis_no_wr", 32'(O_rd_we), 32'd0);

    // Watchdog: no grant, abort after 8 REQ cycles
    applyStimulus(4'b0011, 32'h8000_0020, 32'h0, 32'h0, 1'b1, 5'd9);
    tick();
    I_valid   = 1'b0;
    reqCycles = 0;
    for (int i = 0; i < 20; i++) begin
      if (!O_mem_req) break;
      reqCycles++;
      tick();
    end
    checkOutput("wd_req_cycles", 32'(reqCycles), 32'd8);
    checkOutput("wd_bus_err", 32'(O_bus_err), 32'd1);
    checkOutput("wd_ready", 32'(O_ready), 32'd1);
    checkOutput("wd_no_wr", 32'(O_rd_we), 32'd0);
    tick();
    checkOutput("wd_err_pulse", 32'(O_bus_err), 32'd0);

    // Watchdog: rvalid in the 8th cycle completes normally
    applyStimulus(4'b0011, 32'h8000_0024, 32'h0, 32'h0, 1'b1, 5'd11);
    tick();
    I_valid   = 1'b0;
    I_mem_gnt = 1'b1;
    tick();
    I_mem_gnt = 1'b0;
    for (int i = 0; i < 6; i++) tick();
    I_mem_rvalid = 1'b1;
    I_mem_rdata  = 32'hCAFE_F00D;
    tick();
    I_mem_rvalid = 1'b0;
    checkOutput("wd8_no_err", 32'(O_bus_err), 32'd0);
    checkOutput("wd8_rdwe", 32'(O_rd_we), 32'd1);
    checkOutput("wd8_data", O_rd_wdata, 32'hCAFE_F00D);

    // Back-to-back NONE ops
    applyStimulus(4'b0000, 32'h0, 32'h0, 32'h0000_0055, 1'b1, 5'd0);
    tick();
    checkOutput("none_x0_we", 32'(O_rd_we), 32'd0);
    applyStimulus(4'b0000, 32'h0, 32'h0, 32'h0000_1234, 1'b1, 5'd5);
    tick();
    I_valid = 1'b0;
    checkOutput("none_x5_we", 32'(O_rd_we), 32'd1);
    checkOutput("none_x5_addr", 32'(O_rd_waddr), 32'd5);
    checkOutput("none_x5_data", O_rd_wdata, 32'h0000_1234);

    // Reset while waiting for a response
    applyStimulus(4'b0011, 32'h8000_0040, 32'h0, 32'h0, 1'b1, 5'd12);
    tick();
    I_valid   = 1'b0;
    I_mem_gnt = 1'b1;
    tick();
    I_mem_gnt = 1'b0;
    rst = 1'b1;
    #1;
    checkOutput("arst_req", 32'(O_mem_req), 32'd0);
    checkOutput("arst_addr", O_mem_addr, 32'h0);
    checkOutput("arst_ready", 32'(O_ready), 32'd1);
    tick();
    rst = 1'b0;
    tick();
    I_mem_rvalid = 1'b1;
    I_mem_rdata  = 32'h1234_5678;
    tick();
    I_mem_rvalid = 1'b0;
    checkOutput("arst_late_rvalid", 32'(O_rd_we), 32'd0);
    checkOutput("arst_no_req", 32'(O_mem_req), 32'd0);

    $display("test done: total=%0d bad=%0d", totalCount, badCount);
    $finish;
  end

endmodule

// File: doc/lsu_wb.md
Name: lsu_wb

Overview:
- Load/store and writeback stage that sits directly upstream of the general-purpose register file and drives its single write port (rd_we / rd_waddr / rd_wdata).
- Takes one instruction at a time from execute over a valid/ready handshake.
- ALU results pass straight through to the write port.
- Loads and stores run a request/grant/response transaction on the data bus. Loads are sign- or zero-extended before writeback.

Parameters:
TIMEOUT, 255, bus watchdog: maximum cycles spent in REQ+WAIT before abort (1..255)

Ports:
clk  in  1  clock, rising edge
rst  in  1  reset; asynchronous, active-high
I_valid  in  1  execute presents an instruction
O_ready  out  1  stage can accept (combinational: state==IDLE)
I_op  in  4  0000 NONE, 0001 LB, 0010 LH, 0011 LW, 0100 LBU, 0101 LHU, 1001 SB, 1010 SH, 1011 SW; all other codes treated as NONE
I_addr  in  32  effective memory address
I_wdata  in  32  store data (rs2)
I_alu_result  in  32  writeback value for NONE
I_rd_we  in  1  instruction writes rd
I_rd_waddr  in  5  destination register
O_mem_req  out  1  bus request
I_mem_gnt  in  1  bus grant
O_mem_we  out  1  1 = store
O_mem_addr  out  32  word-aligned address {addr[31:2],2'b00}
O_mem_wstrb  out  4  byte strobes
O_mem_wdata  out  32  lane-replicated store data
I_mem_rvalid  in  1  response (load data valid / store ack)
I_mem_rdata  in  32  load data
O_rd_we  out  1  register-file write enable
O_rd_waddr  out  5  register-file write address
O_rd_wdata  out  32  register-file write data
O_misalign  out  1  one-cycle misaligned-access pulse
O_bus_err  out  1  one-cycle watchdog-abort pulse

Behaviour:
- Reset state: IDLE, watchdog = 0, captured fields = 0.
- Reset output values: O_mem_req, O_mem_we, O_mem_wstrb, O_mem_addr, O_mem_wdata, O_rd_we, O_rd_waddr, O_rd_wdata, O_misalign and O_bus_err are all 0.
- O_ready is 1 during reset.
- O_rd_*, O_misalign and O_bus_err are registered. O_rd_we, O_misalign and O_bus_err are single-cycle pulses.
- O_rd_we is never 1 when O_rd_waddr == 0.
- IDLE, handshake fires (I_valid & O_ready):
  - NONE: on the next cycle O_rd_we = I_rd_we & (I_rd_waddr != 0) and O_rd_wdata = I_alu_result. Stay in IDLE. Throughput is 1 per cycle.
  - Misaligned access (LH/LHU/SH with addr[0]=1; LW/SW with addr[1:0] != 0): O_misalign pulses on the next cycle. No bus activity, no rd write. Stay in IDLE.
  - Aligned memory op: capture op, addr[1:0], rd and store data, then go to REQ.
- REQ:
  - O_mem_req = 1. O_mem_we, O_mem_addr, O_mem_wstrb and O_mem_wdata are held stable.
  - I_mem_gnt = 1 sampled on an edge moves to WAIT; O_mem_req drops the following cycle.
  - I_mem_rvalid is ignored while in REQ.
- WAIT:
  - O_mem_req = 0. The first I_mem_rvalid returns the stage to IDLE.
  - Load: O_rd_* written on the next cycle (load-to-write latency 1 cycle after rvalid).
  - Store: rvalid is the write acknowledge; no rd write.
  - A load with rd = 0 completes the bus transaction without a write.
- Store encoding:
  - SB: wstrb = 1 << addr[1:0]; wdata = byte replicated x4.
  - SH: wstrb = 0011 if addr[1]=0, else 1100; wdata = halfword replicated x2.
  - SW: wstrb = 1111.
- Load extraction: lane selected by captured addr[1:0].
  - LB/LH sign-extend.
  - LBU/LHU zero-extend.
  - LW passes the word through.
- Watchdog:
  - Counts each cycle spent in REQ or WAIT and clears on entry to REQ.
  - When the count reaches TIMEOUT without completion: O_bus_err pulses, O_mem_req drops, return to IDLE, no rd write.
  - If rvalid arrives in the same cycle the count reaches TIMEOUT, completion wins and there is no error.
- Back-to-back: O_ready is 0 in REQ and WAIT. A new instruction can be accepted in the cycle after return to IDLE.
- I_mem_rvalid or I_mem_gnt seen in IDLE is ignored.
- Reset mid-transaction: everything returns to reset values immediately (asynchronous). O_mem_req drops without waiting for a clock. A late rvalid is ignored.

Test Plan:
- LW addr 0x80000104, rd = x10. gnt is 1 in the first REQ cycle; rvalid arrives 2 cycles later with 0xDEADBEEF. Required: mem_addr 0x80000104, wstrb 0000, req high for exactly 1 cycle; one cycle after rvalid, O_rd_we = 1, waddr = 10, wdata = 0xDEADBEEF.
- rdata 0x80FF1234:
  - LB addr ...03 -> 0xFFFFFF80.
  - LBU addr ...03 -> 0x00000080.
  - LH addr ...02 -> 0xFFFF80FF.
  - LHU addr ...00 -> 0x00001234.
- SH addr 0x80000006, wdata 0x0000ABCD. Required: mem_we = 1, mem_addr 0x80000004, wstrb 1100, wdata 0xABCDABCD. After ack, no O_rd_we and O_ready returns to 1.
- LW addr 0x80000002. Required: O_misalign = 1 for one cycle, O_mem_req stays 0, O_ready stays 1.
- TIMEOUT = 8, gnt held 0. Required: O_bus_err pulses after 8 REQ cycles, req = 0, IDLE. Separately, gnt given and rvalid arriving on the 8th cycle completes normally with no error.
- Back-to-back NONE ops: (rd x0, 0x55), (rd x5, 0x1234) -> no write, then x5 = 0x1234 on consecutive cycles. Then LW with rst asserted in WAIT: req = 0 and outputs 0 immediately; a later rvalid produces no write.
